// File: rtl/fb_pixel_writer.sv
// Pixel stream to framebuffer word writer: buffers (x, y, colour) pixels, converts them to byte
// addresses and issues 32-bit Avalon-style writes; also fills the whole frame with one colour.
module fb_pixel_writer #(
   parameter int FB_WIDTH   = 640,
   parameter int FB_HEIGHT  = 480,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [25:0] base_addr,
   input  logic        pix_valid,
   output logic        pix_ready,
   input  logic [9:0]  pix_x,
   input  logic [9:0]  pix_y,
   input  logic [31:0] pix_color,
   input  logic        clear_start,
   input  logic [31:0] clear_color,
   output logic        busy,
   output logic        clear_done,
   output logic [25:0] m_address,
   output logic        m_write,
   output logic [31:0] m_writedata,
   input  logic        m_waitrequest
);

   localparam int NPIX    = FB_WIDTH * FB_HEIGHT;
   localparam int IDX_W   = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int ENTRY_W = 26 + 32;

   localparam logic [1:0] MODE_RUN      = 2'd0;
   localparam logic [1:0] MODE_CLR_WAIT = 2'd1;
   localparam logic [1:0] MODE_CLEAR    = 2'd2;
   localparam logic [1:0] MODE_DONE     = 2'd3;

   localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(NPIX - 1);
   localparam logic [PTR_W:0]   FIFO_FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [31:0]      WIDTH_U       = FB_WIDTH;
   localparam logic [31:0]      HEIGHT_U      = FB_HEIGHT;

   logic [1:0]        mode_q, mode_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [IDX_W-1:0]  idx_inc;
   logic [31:0]       clr_color_q, clr_color_d;
   logic              m_write_q, m_write_d;
   logic [25:0]       m_address_q, m_address_d;
   logic [31:0]       m_writedata_q, m_writedata_d;

   logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]     count_q, count_d;
   logic               fifo_full, fifo_empty;
   logic               push, pop;
   logic [ENTRY_W-1:0] head;

   logic               in_range;
   logic [25:0]        pix_off;
   logic [25:0]        pix_addr;
   logic               accept;

   // Address arithmetic is done entirely in 26 bits so it wraps like the bus does.
   assign pix_off  = (26'(pix_y) * 26'(FB_WIDTH) + 26'(pix_x)) << 2;
   assign pix_addr = base_addr + pix_off;
   assign in_range = (32'(pix_x) < WIDTH_U) && (32'(pix_y) < HEIGHT_U);

   assign fifo_full  = (count_q == FIFO_FULL_CNT);
   assign fifo_empty = (count_q == '0);
   assign pix_ready  = !fifo_full && (mode_q == MODE_RUN);
   assign push       = pix_valid && pix_ready && in_range;
   assign head       = fifo_mem[rd_ptr_q];

   assign accept  = m_write_q && !m_waitrequest;
   assign idx_inc = idx_q + 1'b1;

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= {pix_addr, pix_color};
      end
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_d;
      end
   end

   always_comb begin
      mode_d        = mode_q;
      idx_d         = idx_q;
      clr_color_d   = clr_color_q;
      m_write_d     = m_write_q;
      m_address_d   = m_address_q;
      m_writedata_d = m_writedata_q;
      pop           = 1'b0;

      case (mode_q)
         MODE_RUN, MODE_CLR_WAIT: begin
            // Bus slot is free when idle or being accepted this edge: refill from the FIFO head.
            if (!m_write_q || accept) begin
               if (!fifo_empty) begin
                  pop           = 1'b1;
                  m_write_d     = 1'b1;
                  m_address_d   = head[ENTRY_W-1:32];
                  m_writedata_d = head[31:0];
               end else begin
                  m_write_d = 1'b0;
               end
            end
            if (mode_q == MODE_RUN && clear_start) begin
               mode_d      = MODE_CLR_WAIT;
               clr_color_d = clear_color;
            end
            if (mode_q == MODE_CLR_WAIT && fifo_empty && !m_write_q) begin
               mode_d        = MODE_CLEAR;
               idx_d         = '0;
               m_write_d     = 1'b1;
               m_address_d   = base_addr;
               m_writedata_d = clr_color_q;
            end
         end
         MODE_CLEAR: begin
            if (accept) begin
               if (idx_q == IDX_LAST) begin
                  m_write_d = 1'b0;
                  mode_d    = MODE_DONE;
               end else begin
                  idx_d       = idx_inc;
                  m_address_d = base_addr + (26'(idx_inc) << 2);
               end
            end
         end
         default: begin
            mode_d = MODE_RUN;
            idx_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mode_q        <= MODE_RUN;
         idx_q         <= '0;
         clr_color_q   <= '0;
         m_write_q     <= 1'b0;
         m_address_q   <= '0;
         m_writedata_q <= '0;
      end else begin
         mode_q        <= mode_d;
         idx_q         <= idx_d;
         clr_color_q   <= clr_color_d;
         m_write_q     <= m_write_d;
         m_address_q   <= m_address_d;
         m_writedata_q <= m_writedata_d;
      end
   end

   assign m_write     = m_write_q;
   assign m_address   = m_address_q;
   assign m_writedata = m_writedata_q;
   assign clear_done  = (mode_q == MODE_DONE);
   assign busy        = (mode_q != MODE_RUN) || !fifo_empty || m_write_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer on a 4x2 frame at base 0x100; every accepted bus write is logged.
module tb_fb_pixel_writer;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [25:0] base_addr = 26'h100;
   logic        pix_valid = 1'b0;
   logic        pix_ready;
   logic [9:0]  pix_x = '0;
   logic [9:0]  pix_y = '0;
   logic [31:0] pix_color = '0;
   logic        clear_start = 1'b0;
   logic [31:0] clear_color = '0;
   logic        busy;
   logic        clear_done;
   logic [25:0] m_address;
   logic        m_write;
   logic [31:0] m_writedata;
   logic        m_waitrequest = 1'b0;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          last_acc_cyc = -10;
   logic        toggle_en = 1'b0;
   logic [25:0] wa_q[$];
   logic [31:0] wd_q[$];

   fb_pixel_writer #(
      .FB_WIDTH  (4),
      .FB_HEIGHT (2),
      .FIFO_DEPTH(4)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .base_addr    (base_addr),
      .pix_valid    (pix_valid),
      .pix_ready    (pix_ready),
      .pix_x        (pix_x),
      .pix_y        (pix_y),
      .pix_color    (pix_color),
      .clear_start  (clear_start),
      .clear_color  (clear_color),
      .busy         (busy),
      .clear_done   (clear_done),
      .m_address    (m_address),
      .m_write      (m_write),
      .m_writedata  (m_writedata),
      .m_waitrequest(m_waitrequest)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (reset && m_write && !m_waitrequest) begin
         wa_q.push_back(m_address);
         wd_q.push_back(m_writedata);
         last_acc_cyc = cyc;
         $display("write  addr=%h data=%h", m_address, m_writedata);
      end
      cyc++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      if (toggle_en) m_waitrequest = ~m_waitrequest;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clear_log();
      wa_q.delete();
      wd_q.delete();
   endtask

   // Returns one cycle after the handshake cycle.
   task automatic push_pix(input logic [9:0] x, input logic [9:0] y, input logic [31:0] c);
      int guard = 0;
      pix_x = x;
      pix_y = y;
      pix_color = c;
      pix_valid = 1'b1;
      while (!pix_ready && guard < 200) begin
         step();
         guard++;
      end
      check("push_ready", pix_ready, 1);
      step();
      pix_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   pushed;
      logic hs;
      logic seen;
      int   gap;
      int   early;
      int   guard;

      // Reset state
      steps(3);
      reset = 1'b1;
      step();
      check("rst_pix_ready", pix_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_clear_done", clear_done, 0);
      check("rst_m_write", m_write, 0);
      check("rst_m_address", m_address, 0);
      check("rst_m_writedata", m_writedata, 0);

      // Single pixel (2,1): address 0x100 + (1*4+2)*4 = 0x118
      clear_log();
      push_pix(10'd2, 10'd1, 32'hDEADBEEF);
      check("single_n1_write", m_write, 0);
      step();
      check("single_n2_write", m_write, 1);
      check("single_addr", m_address, 26'h118);
      check("single_data", m_writedata, 32'hDEADBEEF);
      step();
      check("single_done_write", m_write, 0);
      check("single_done_busy", busy, 0);
      check("single_count", wa_q.size(), 1);

      // Backpressure: one write stalled on the bus plus a full FIFO
      clear_log();
      m_waitrequest = 1'b1;
      pushed = 0;
      for (int c = 0; c < 12; c++) begin
         if (pushed < 6) begin
            pix_x = 10'(pushed % 4);
            pix_y = 10'(pushed / 4);
            pix_color = 32'hA0 + 32'(pushed);
            pix_valid = 1'b1;
         end
         hs = pix_valid && pix_ready;
         step();
         if (hs) pushed++;
      end
      pix_valid = 1'b0;
      check("bp_pushed", pushed, 5);
      check("bp_ready_low", pix_ready, 0);
      check("bp_busy", busy, 1);
      check("bp_m_write", m_write, 1);
      check("bp_addr", m_address, 26'h100);
      check("bp_data", m_writedata, 32'hA0);
      steps(3);
      check("bp_hold_addr", m_address, 26'h100);
      check("bp_hold_data", m_writedata, 32'hA0);
      m_waitrequest = 1'b0;
      steps(10);
      check("bp_count", wa_q.size(), 5);
      for (int i = 0; i < 5 && i < wa_q.size(); i++) begin
         check($sformatf("bp_addr%0d", i), wa_q[i], 26'h100 + 26'(4 * i));
         check($sformatf("bp_data%0d", i), wd_q[i], 32'hA0 + 32'(i));
      end
      check("bp_idle_busy", busy, 0);

      // Out-of-range pixels are swallowed
      clear_log();
      push_pix(10'd4, 10'd0, 32'h11);
      check("drop_x_busy", busy, 0);
      push_pix(10'd0, 10'd2, 32'h22);
      check("drop_y_busy", busy, 0);
      steps(3);
      check("drop_busy_later", busy, 0);
      check("drop_count", wa_q.size(), 0);

      // Clear with waitrequest toggling every cycle
      clear_log();
      clear_color = 32'h00FF00FF;
      clear_start = 1'b1;
      step();
      clear_start = 1'b0;
      clear_color = 32'h0;
      check("clr_ready_low", pix_ready, 0);
      check("clr_busy", busy, 1);
      toggle_en = 1'b1;
      seen = 1'b0;
      gap = -1;
      guard = 0;
      while (!seen && guard < 100) begin
         step();
         guard++;
         if (clear_done) begin
            seen = 1'b1;
            gap = cyc - last_acc_cyc;
         end
      end
      toggle_en = 1'b0;
      m_waitrequest = 1'b0;
      check("clr_done_seen", seen, 1);
      check("clr_done_gap", gap, 1);
      step();
      check("clr_done_once", clear_done, 0);
      check("clr_ready_back", pix_ready, 1);
      check("clr_busy_end", busy, 0);
      check("clr_count", wa_q.size(), 8);
      for (int i = 0; i < 8 && i < wa_q.size(); i++) begin
         check($sformatf("clr_addr%0d", i), wa_q[i], 26'h100 + 26'(4 * i));
         check($sformatf("clr_data%0d", i), wd_q[i], 32'h00FF00FF);
      end

      // Clear requested alongside a pixel handshake with traffic queued
      clear_log();
      m_waitrequest = 1'b1;
      push_pix(10'd1, 10'd0, 32'hB1);
      push_pix(10'd2, 10'd0, 32'hB2);
      push_pix(10'd3, 10'd0, 32'hB3);
      pix_x = 10'd0;
      pix_y = 10'd1;
      pix_color = 32'hB4;
      pix_valid = 1'b1;
      clear_color = 32'h12345678;
      clear_start = 1'b1;
      check("ct_ready_at_clear", pix_ready, 1);
      step();
      clear_start = 1'b0;
      pix_x = 10'd3;
      pix_y = 10'd1;
      pix_color = 32'h55;
      m_waitrequest = 1'b0;
      early = 0;
      seen = 1'b0;
      guard = 0;
      while (!seen && guard < 100) begin
         if (clear_done) begin
            seen = 1'b1;
         end else begin
            if (pix_ready) early++;
            step();
            guard++;
         end
      end
      check("ct_done_seen", seen, 1);
      check("ct_no_early_accept", early, 0);
      step();
      check("ct_ready_after", pix_ready, 1);
      step();
      pix_valid = 1'b0;
      steps(4);
      check("ct_count", wa_q.size(), 13);
      if (wa_q.size() == 13) begin
         check("ct_d0", wd_q[0], 32'hB1);
         check("ct_d1", wd_q[1], 32'hB2);
         check("ct_d2", wd_q[2], 32'hB3);
         check("ct_d3", wd_q[3], 32'hB4);
         check("ct_a3", wa_q[3], 26'h110);
         check("ct_a4", wa_q[4], 26'h100);
         check("ct_d4", wd_q[4], 32'h12345678);
         check("ct_a11", wa_q[11], 26'h11C);
         check("ct_a12", wa_q[12], 26'h11C);
         check("ct_d12", wd_q[12], 32'h55);
      end

      // Reset while the clear is at idx 3
      clear_log();
      clear_color = 32'hCAFE0000;
      clear_start = 1'b1;
      step();
      clear_start = 1'b0;
      seen = 1'b0;
      guard = 0;
      while (!seen && guard < 50) begin
         if (m_write && m_address == 26'h10C) seen = 1'b1;
         else begin
            step();
            guard++;
         end
      end
      check("rmc_idx3_seen", seen, 1);
      reset = 1'b0;
      #1;
      check("rmc_m_write", m_write, 0);
      check("rmc_busy", busy, 0);
      check("rmc_clear_done", clear_done, 0);
      steps(2);
      reset = 1'b1;
      step();
      clear_log();
      push_pix(10'd1, 10'd1, 32'h77);
      steps(4);
      check("rmc_count", wa_q.size(), 1);
      if (wa_q.size() == 1) begin
         check("rmc_addr", wa_q[0], 26'h114);
         check("rmc_data", wd_q[0], 32'h77);
      end
      check("rmc_busy_end", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
